// File: rtl/gb_mem_pkg.sv
// Shared types and constants for the cartridge memory path.
//   MBC_ADDR_W      byte address width used by the bank controller
//   SD_DATA_W       SDRAM data word width
//   SDRAM_RAM_BASE  byte address where cartridge RAM starts in SDRAM
//   port_state_t    request FSM states of mbc_sdram_port
//   mbc_req_t       one captured CPU access (address, direction, write byte)
//   sel_byte        picks the addressed byte out of a 16-bit word
//   byte_en         SDRAM byte enable for a single-byte write
package gb_mem_pkg;

  localparam int MBC_ADDR_W = 26;
  localparam int SD_DATA_W = 16;
  localparam logic [MBC_ADDR_W-1:0] SDRAM_RAM_BASE = 26'h2000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } port_state_t;

  typedef struct packed {
    logic [MBC_ADDR_W-1:0] addr;
    logic                  we;
    logic [7:0]            wdata;
  } mbc_req_t;

  // Address bit 0 = 0 selects the low byte, 1 selects the high byte.
  function automatic logic [7:0] sel_byte(input logic [SD_DATA_W-1:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [1:0] byte_en(input logic hi);
    return hi ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mbc_access_detect.sv
// Detects the start of a new CPU access on the bank-controller bus.
//   clk, reset        clock and synchronous active-low reset
//   MBC_ADDR          byte address
//   MBC_RD, MBC_WR    level strobes held for the whole CPU access
//   MBC_DATA_out      write data byte
//   new_acc           high in any cycle that starts a new access
//   req               the access presented this cycle, packed for the port
// A strobe rising, or the address moving while a strobe is held, both count
// as a new access. With both strobes high the access is a write.
module mbc_access_detect
  import gb_mem_pkg::*;
#(
  parameter int ADDR_W = MBC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] MBC_ADDR,
  input  logic              MBC_RD,
  input  logic              MBC_WR,
  input  logic [7:0]        MBC_DATA_out,
  output logic              new_acc,
  output mbc_req_t          req
);

  logic              prev_rd;
  logic              prev_wr;
  logic [ADDR_W-1:0] prev_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_rd   <= 1'b0;
      prev_wr   <= 1'b0;
      prev_addr <= '0;
    end else begin
      prev_rd   <= MBC_RD;
      prev_wr   <= MBC_WR;
      prev_addr <= MBC_ADDR;
    end
  end

  always_comb begin
    new_acc = (MBC_RD & ~prev_rd) | (MBC_WR & ~prev_wr) |
              ((MBC_RD | MBC_WR) & (MBC_ADDR != prev_addr));
    req.addr  = MBC_ADDR_W'(MBC_ADDR);
    req.we    = MBC_WR;
    req.wdata = MBC_DATA_out;
  end

endmodule

// File: rtl/mbc_sdram_port.sv
// SDRAM-side responder for the cartridge bank controller.
//   clk, reset      clock and synchronous active-low reset
//   MBC_ADDR/RD/WR/DATA_out   byte-wide request from the bank controller
//   MBC_DATA_in     read byte back to the bank controller (holds between reads)
//   MEM_BUSY        access in flight or waiting in the pending slot
//   CACHE_INV       one-cycle pulse, drops the read cache
//   ERR             sticky {timeout, pending overflow}, cleared by reset only
//   sd_*            16-bit SDRAM request port, req held until a one-cycle ack
//   state_dbg       current FSM state, for observation only
// Handshake: sd_req rises together with stable sd_addr/sd_we/sd_be/sd_wdata,
// which do not change until the cycle sd_ack is sampled high; sd_req is
// dropped on that same edge. For reads sd_rdata is valid with sd_ack.
// A one-word write-through cache serves repeat reads of the same word, and a
// one-deep slot holds an access that arrives while a request is outstanding.
module mbc_sdram_port
  import gb_mem_pkg::*;
#(
  parameter int ADDR_W  = MBC_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    MBC_ADDR,
  input  logic                 MBC_RD,
  input  logic                 MBC_WR,
  input  logic [7:0]           MBC_DATA_out,
  output logic [7:0]           MBC_DATA_in,
  output logic                 MEM_BUSY,
  input  logic                 CACHE_INV,
  output logic [1:0]           ERR,
  output logic [ADDR_W-2:0]    sd_addr,
  output logic                 sd_req,
  output logic                 sd_we,
  output logic [1:0]           sd_be,
  output logic [SD_DATA_W-1:0] sd_wdata,
  input  logic                 sd_ack,
  input  logic [SD_DATA_W-1:0] sd_rdata,
  output port_state_t          state_dbg
);

  // Last count value before abort: sd_req stays high for TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  port_state_t          state;
  logic                 new_acc;
  mbc_req_t             acc_req;
  mbc_req_t             pend;
  logic                 pend_valid;
  logic                 cache_valid;
  logic [ADDR_W-2:0]    cache_tag;
  logic [SD_DATA_W-1:0] cache_data;
  logic                 rd_hi;
  logic [7:0]           tmo_cnt;
  logic                 err_tmo;
  logic                 err_ovf;

  logic                 serve_pend;
  logic                 serve_new;
  logic                 capture;
  mbc_req_t             lreq;
  logic [ADDR_W-1:0]    l_addr;
  logic                 l_hit;

  mbc_access_detect #(.ADDR_W(ADDR_W)) u_detect (
    .clk          (clk),
    .reset        (reset),
    .MBC_ADDR     (MBC_ADDR),
    .MBC_RD       (MBC_RD),
    .MBC_WR       (MBC_WR),
    .MBC_DATA_out (MBC_DATA_out),
    .new_acc      (new_acc),
    .req          (acc_req)
  );

  // In IDLE the pending slot has priority over a fresh access; the fresh one
  // then takes the slot that is being vacated on the same edge.
  always_comb begin
    serve_pend = (state == IDLE) && pend_valid;
    serve_new  = (state == IDLE) && new_acc && !pend_valid;
    capture    = new_acc && ((state != IDLE) || pend_valid);
    lreq       = serve_pend ? pend : acc_req;
    l_addr     = lreq.addr[ADDR_W-1:0];
    l_hit      = cache_valid && (cache_tag == l_addr[ADDR_W-1:1]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pend        <= '0;
      pend_valid  <= 1'b0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      rd_hi       <= 1'b0;
      tmo_cnt     <= '0;
      err_tmo     <= 1'b0;
      err_ovf     <= 1'b0;
      MBC_DATA_in <= 8'hFF;
      sd_addr     <= '0;
      sd_req      <= 1'b0;
      sd_we       <= 1'b0;
      sd_be       <= 2'b00;
      sd_wdata    <= '0;
    end else begin
      // Pending slot: capture while busy, overflow if it is still occupied.
      if (capture) begin
        if (pend_valid && !serve_pend) begin
          err_ovf <= 1'b1;
        end else begin
          pend       <= acc_req;
          pend_valid <= 1'b1;
        end
      end else if (serve_pend) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (serve_pend || serve_new) begin
            if (lreq.we) begin
              state    <= WR_REQ;
              sd_req   <= 1'b1;
              sd_we    <= 1'b1;
              sd_addr  <= l_addr[ADDR_W-1:1];
              sd_be    <= byte_en(l_addr[0]);
              sd_wdata <= {lreq.wdata, lreq.wdata};
              tmo_cnt  <= '0;
              // Write-through keeps the cached word coherent with SDRAM.
              if (l_hit) begin
                if (l_addr[0]) cache_data[15:8] <= lreq.wdata;
                else           cache_data[7:0]  <= lreq.wdata;
              end
            end else if (l_hit) begin
              MBC_DATA_in <= sel_byte(cache_data, l_addr[0]);
            end else begin
              state   <= RD_REQ;
              sd_req  <= 1'b1;
              sd_we   <= 1'b0;
              sd_addr <= l_addr[ADDR_W-1:1];
              sd_be   <= 2'b11;
              rd_hi   <= l_addr[0];
              tmo_cnt <= '0;
            end
          end
        end

        RD_REQ: begin
          if (sd_ack) begin
            cache_tag   <= sd_addr;
            cache_data  <= sd_rdata;
            cache_valid <= 1'b1;
            MBC_DATA_in <= sel_byte(sd_rdata, rd_hi);
            sd_req      <= 1'b0;
            state       <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_tmo     <= 1'b1;
            MBC_DATA_in <= 8'hFF;
            sd_req      <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        WR_REQ: begin
          if (sd_ack) begin
            sd_req <= 1'b0;
            state  <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_tmo <= 1'b1;
            sd_req  <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: begin
          sd_req <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // Invalidate wins over a load on the same edge.
      if (CACHE_INV) cache_valid <= 1'b0;
    end
  end

  assign MEM_BUSY  = (state != IDLE) || pend_valid;
  assign ERR       = {err_tmo, err_ovf};
  assign state_dbg = state;

endmodule
